// File: rtl/bit_diff_source.sv
// Purpose: LFSR word source on a valid/ready port, plus a golden bit-diff (2*popcount - WIDTH) per transferred word.
// Latency: first data_valid 1+gap cycles after start; expected_valid 2 cycles after each transfer; done 3 cycles after the last.
// Backpressure: data/data_valid held while ready=0; after a transfer, re-issue waits until ready is seen low.
module bit_diff_source #(
    parameter int                  WIDTH       = 32,
    parameter logic [WIDTH-1:0]    LFSR_SEED   = WIDTH'(32'hACE1_2345),
    parameter logic [WIDTH-1:0]    LFSR_TAPS   = WIDTH'(32'h8020_0003),
    parameter int                  COUNT_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [COUNT_WIDTH-1:0]                 num_words,
    input  logic [7:0]                             gap,
    input  logic                                   ready,
    output logic [WIDTH-1:0]                       data,
    output logic                                   data_valid,
    output logic signed [$clog2(2*WIDTH+1)-1:0]    expected,
    output logic                                   expected_valid,
    output logic                                   busy,
    output logic                                   done,
    output logic [COUNT_WIDTH-1:0]                 issued_count
);

    localparam int EW = $clog2(2*WIDTH+1);
    localparam int NB = (WIDTH + 7) / 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GAP      = 3'd1,
        ISSUE    = 3'd2,
        WAIT_LOW = 3'd3,
        FINISH   = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [COUNT_WIDTH-1:0] remaining_r;
    logic [7:0]             gap_r;
    logic [7:0]             gap_cnt;
    logic                   xfer;
    logic                   start_go;
    logic                   start_empty;
    logic                   p1_vld;
    logic [3:0]             part_r [NB];
    logic [NB*8-1:0]        data_pad;
    logic [EW-1:0]          pop_sum;
    logic [EW-1:0]          diff_c;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ LFSR_TAPS;
        end
        return n;
    endfunction

    function automatic logic [3:0] pop8(input logic [7:0] b);
        logic [3:0] c;
        c = '0;
        for (int k = 0; k < 8; k++) begin
            c = c + {3'b000, b[k]};
        end
        return c;
    endfunction

    assign xfer        = data_valid && ready;
    assign start_go    = (state == IDLE) && start && (num_words != '0);
    assign start_empty = (state == IDLE) && start && (num_words == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; WAIT_LOW blocks re-issue until the sink drops ready
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_go) begin
                    state_nxt = (gap != 8'd0) ? GAP : ISSUE;
                end
            end
            GAP: begin
                if (gap_cnt <= 8'd1) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (xfer) begin
                    state_nxt = (remaining_r == COUNT_WIDTH'(1)) ? FINISH : WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!ready) begin
                    state_nxt = (gap_r != 8'd0) ? GAP : ISSUE;
                end
            end
            FINISH: begin
                // Earlier transfers have already drained; the strobe seen here is the last word's
                if (expected_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state != IDLE);
    end

    // Gap counter: loaded on every non-GAP cycle so it is primed on entry, counts down inside GAP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= 8'd0;
        end else if (state != GAP) begin
            gap_cnt <= (state == IDLE) ? gap : gap_r;
        end else begin
            gap_cnt <= gap_cnt - 8'd1;
        end
    end

    // Run bookkeeping: latched run parameters, transfer count and the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining_r  <= '0;
            gap_r        <= 8'd0;
            issued_count <= '0;
            done         <= 1'b0;
        end else begin
            if (start_go) begin
                remaining_r  <= num_words;
                gap_r        <= gap;
                issued_count <= '0;
            end else if (xfer) begin
                remaining_r  <= remaining_r - COUNT_WIDTH'(1);
                issued_count <= issued_count + COUNT_WIDTH'(1);
            end
            done <= start_empty || ((state == FINISH) && expected_valid);
        end
    end

    // Handshake side: valid tracks ISSUE, LFSR word advances only on a transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid <= 1'b0;
            data       <= LFSR_SEED;
        end else begin
            data_valid <= (state_nxt == ISSUE);
            if (xfer) begin
                data <= lfsr_step(data);
            end
        end
    end

    // Zero-pad the word to whole bytes for the partial popcounts
    always_comb begin
        data_pad = '0;
        data_pad[WIDTH-1:0] = data;
    end

    // Golden stage 1: per-byte popcounts of the transferred word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_vld <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                part_r[i] <= 4'd0;
            end
        end else begin
            p1_vld <= xfer;
            if (xfer) begin
                for (int i = 0; i < NB; i++) begin
                    part_r[i] <= pop8(data_pad[i*8 +: 8]);
                end
            end
        end
    end

    // Sum the partials and form 2*popcount - WIDTH in two's complement
    always_comb begin
        pop_sum = '0;
        for (int i = 0; i < NB; i++) begin
            pop_sum = pop_sum + EW'(part_r[i]);
        end
        diff_c = {pop_sum[EW-2:0], 1'b0} - EW'(WIDTH);
    end

    // Golden stage 2: registered bit-diff with its one-cycle strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expected_valid <= 1'b0;
            expected       <= '0;
        end else begin
            expected_valid <= p1_vld;
            if (p1_vld) begin
                expected <= $signed(diff_c);
            end
        end
    end

endmodule
